hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mul_busy_cnt.sv | 36 +++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam int MUL_LAT     = 4;
    localparam int STALL_CNT_W = 16;
    localparam int CNT_W       = 3;

    // Value loaded on multiply start so that the start cycle plus the busy
    // cycles with a non-zero count add up to MUL_LAT stall cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

endpackage

// File: rtl/mul_busy_cnt.sv
// Down-counter that sequences the multi-cycle multiply: load, decrement, zero flag.
module mul_busy_cnt
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle multiply stall.
// Multiply sequencing is built only when HAZARD_CTRL_MUL_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UseRt,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_WR_out,
    input  logic                   EX_BranchTaken,
    input  logic                   EX_MulStart,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   ID_EX_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   EX_M_Bubble,
    output logic                   mul_done,
    output logic [STALL_CNT_W-1:0] stall_count
);

`ifdef HAZARD_CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_e                   state_q, state_d;
    logic [STALL_CNT_W-1:0]   stall_count_q, stall_count_d;
    logic                     busy, load_use, branch, mul_start;
    logic                     cnt_load, cnt_dec, cnt_zero;

    mul_busy_cnt u_mul_busy_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (MUL_LOAD),
        .zero_o     (cnt_zero)
    );

    // Events are masked while rst is high so outputs show the RUN defaults at once.
    always_comb begin
        busy      = MUL_EN && (state_q == MUL_BUSY);
        load_use  = !rst && !busy && EX_MemRead && (EX_WR_out != 5'd0) &&
                    ((EX_WR_out == ID_Rs) || (ID_UseRt && (EX_WR_out == ID_Rt)));
        branch    = !rst && !busy && EX_BranchTaken;
        mul_start = MUL_EN && !rst && !busy && EX_MulStart && !branch && !load_use;

        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_M_Bubble = 1'b0;
        mul_done    = 1'b0;
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (busy) begin
            if (!cnt_zero) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Write = 1'b0;
                EX_M_Bubble = 1'b1;
                cnt_dec     = 1'b1;
            end else begin
                mul_done = 1'b1;
                state_d  = RUN;
            end
        end else if (branch) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (mul_start) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            EX_M_Bubble = 1'b1;
            cnt_load    = 1'b1;
            state_d     = MUL_BUSY;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!PC_Write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
